sec_tick_gen: RTL and testbench
===============================

// Module: sec_tick_gen
// PURPOSE
//  Prescaler feeding the LED up-counter. Divides clk to a 1/2/4/8 Hz rate and emits a
//  one-cycle one_sec_flag pulse per period. A debounced push button toggles run/pause.
//  One instance per board top; one_sec_flag connects directly to the counter stage.
// PARAMETERS
//  CLK_HZ        50_000_000  clk frequency in Hz; must be a multiple of 8 and >= 16
//  DEBOUNCE_CYC  1_000_000   consecutive stable cycles before a button level is accepted
// PORTS
//  clk           in   1  system clock; the only clock in the block
//  rst           in   1  synchronous reset, active-high
//  btn_n         in   1  raw run/pause push button, active-low, asynchronous to clk
//  speed_sel     in   2  tick rate: 00=1 Hz, 01=2 Hz, 10=4 Hz, 11=8 Hz
//  one_sec_flag  out  1  single-cycle tick pulse, registered
//  running       out  1  1 = ticking, 0 = paused, registered
// BEHAVIOUR
//  - Reset: all state is cleared on the clk edge where rst=1.
//    Reset values: one_sec_flag=0, running=1, prescale cnt=0, debounce cnt=0.
//    Sync FFs=1, stable btn=1 (released), registered speed_sel=00.
//    A reset mid-period or mid-debounce discards all progress. No pulse is emitted in a reset cycle.
//  - Button path: btn_n passes through a 2-FF synchroniser to give btn_s.
//    If btn_s != stable, deb_cnt increments. If they are equal, deb_cnt clears to 0.
//    When deb_cnt == DEBOUNCE_CYC-1 and btn_s still differs: stable <= btn_s, deb_cnt <= 0.
//    A press event is stable going 1->0. It toggles running on the next edge. Release does nothing.
//    A glitch shorter than DEBOUNCE_CYC cycles has no effect.
//  - Period: P = CLK_HZ >> sel_q, where sel_q is speed_sel registered once.
//    Counter width is $clog2(CLK_HZ); all compares are unsigned at that width.
//  - Prescaler, running=1: cnt counts 0..P-1 and wraps to 0.
//    The edge where cnt==P-1 sets one_sec_flag=1 for exactly one cycle.
//    The first pulse is high in cycle P after rst deasserts; pulses then repeat every P cycles.
//  - Paused (running=0): cnt holds its value and one_sec_flag=0.
//    On resume, counting continues from the held value, so a partial period is preserved.
//  - Rate change: when speed_sel != sel_q, sel_q updates and cnt clears to 0 on that edge.
//    No pulse is emitted that cycle, even if cnt==P-1. The next pulse follows P_new cycles later.
//  - Simultaneous terminal count and press event: the pulse is still emitted, because the
//    pre-toggle running value is used. running goes 0 on the same edge.
//  - Simultaneous rate change and press event: both take effect; the rate change clears cnt.
//  - one_sec_flag is never high for two consecutive cycles.
//    Latency of running after a settled press is DEBOUNCE_CYC + 3 cycles.
// TESTING (CLK_HZ=16, DEBOUNCE_CYC=4)
//  1 rst pulse, btn_n=1, sel=00 for 64 cycles -> flag high at cycles 16,32,48,64; running=1
//  2 sel=11 -> pulse every 2 cycles; change sel 11->00 at cycle 5 -> no pulse, next at 5+16
//  3 btn_n low 3 cycles then high (glitch) -> running stays 1, pulses unchanged
//  4 btn_n low 10 cycles at cnt=6 -> running=0 after 7 cycles, cnt holds at its value, flag=0;
//    second press -> resumes, next pulse after the remaining 16-held cycles
//  5 press completes on the cycle with cnt==15 -> flag=1 that cycle, running=0 next
//  6 assert rst with cnt=10 and deb_cnt=2 -> all reset values; first pulse 16 cycles after release

Source files
------------

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: prescaler that emits a 1/2/4/8 Hz single-cycle tick, with a debounced run/pause button
//   clk              system clock, the only clock in the block
//   rst              synchronous reset, active-high
//   btn_n_i          raw run/pause push button, active-low, asynchronous to clk
//   speed_sel_i[1:0] tick rate: 00=1 Hz, 01=2 Hz, 10=4 Hz, 11=8 Hz
//   one_sec_flag_o   registered single-cycle tick pulse
//   running_o        registered run state: 1 = ticking, 0 = paused
module sec_tick_gen #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_n_i,
   input  logic [1:0] speed_sel_i,
   output logic       one_sec_flag_o,
   output logic       running_o
);
   localparam int CW = $clog2(CLK_HZ);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
   // Terminal counts P-1 for each rate; P itself may not fit in CW bits, P-1 always does
   localparam logic [CW-1:0] LAST0 = CW'(CLK_HZ - 1);
   localparam logic [CW-1:0] LAST1 = CW'((CLK_HZ >> 1) - 1);
   localparam logic [CW-1:0] LAST2 = CW'((CLK_HZ >> 2) - 1);
   localparam logic [CW-1:0] LAST3 = CW'((CLK_HZ >> 3) - 1);

   logic          sync1_q, sync2_q, stable_q, press_q, running_q, flag_q;
   logic          stable_d, press_d, running_d, flag_d;
   logic [1:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d, last;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic          btn_diff, deb_done, rate_chg, term;

   always_comb begin
      btn_diff  = sync2_q != stable_q;
      deb_done  = btn_diff && (deb_cnt_q == DEB_LAST);
      stable_d  = deb_done ? sync2_q : stable_q;
      deb_cnt_d = (!btn_diff || deb_done) ? '0 : deb_cnt_q + 1'b1;
      // Only the released->pressed transition of the accepted level is a press
      press_d   = deb_done && !sync2_q;
      running_d = press_q ? !running_q : running_q;
      rate_chg  = speed_sel_i != sel_q;
      sel_d     = speed_sel_i;
      last      = (sel_q == 2'd0) ? LAST0 :
                  (sel_q == 2'd1) ? LAST1 :
                  (sel_q == 2'd2) ? LAST2 : LAST3;
      // Pre-toggle running_q is used, so a tick coinciding with a press still fires
      term      = running_q && (cnt_q == last);
      cnt_d     = rate_chg   ? '0    :
                  !running_q ? cnt_q :
                  term       ? '0    : cnt_q + 1'b1;
      flag_d    = term && !rate_chg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         stable_q  <= 1'b1;
         deb_cnt_q <= '0;
         press_q   <= 1'b0;
         running_q <= 1'b1;
         sel_q     <= 2'd0;
         cnt_q     <= '0;
         flag_q    <= 1'b0;
      end else begin
         sync1_q   <= btn_n_i;
         sync2_q   <= sync1_q;
         stable_q  <= stable_d;
         deb_cnt_q <= deb_cnt_d;
         press_q   <= press_d;
         running_q <= running_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         flag_q    <= flag_d;
      end
   end

   assign one_sec_flag_o = flag_q;
   assign running_o      = running_q;
endmodule

// File: tb/tb_sec_tick_gen.sv
// tb_sec_tick_gen: directed self-checking bench for sec_tick_gen at CLK_HZ=16, DEBOUNCE_CYC=4
module tb_sec_tick_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_n = 1'b1;
   logic [1:0] sel = 2'd0;
   logic       flag, running;
   int         npass = 0, nfail = 0, ntotal = 0;

   sec_tick_gen #(.CLK_HZ(16), .DEBOUNCE_CYC(4)) dut (
      .clk(clk),
      .rst(rst),
      .btn_n_i(btn_n),
      .speed_sel_i(sel),
      .one_sec_flag_o(flag),
      .running_o(running)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int k, input logic obs, input logic exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      chk("rst_flag", 0, flag, 1'b0);
      chk("rst_running", 0, running, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      // 1: 1 Hz free run, pulses at 16,32,48,64
      do_reset();
      for (int k = 1; k <= 64; k++) begin
         cyc();
         chk("t1_flag", k, flag, (k % 16) == 0);
         chk("t1_run", k, running, 1'b1);
      end
      // 2: 8 Hz pulses at 3,5,7; switch to 1 Hz while cnt==P-1 -> no pulse, next at 25
      do_reset();
      sel = 2'd3;
      for (int k = 1; k <= 25; k++) begin
         if (k == 9) sel = 2'd0;
         cyc();
         chk("t2_flag", k, flag, (k <= 8) ? (k >= 3 && (k % 2) == 1) : (k == 25));
      end
      // 3: 3-cycle glitch ignored
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         btn_n = !(k <= 3);
         cyc();
         chk("t3_flag", k, flag, k == 16);
         chk("t3_run", k, running, 1'b1);
      end
      // 4: press at cnt=6 pauses at edge 13 (cnt held 13); second press resumes at 37, pulses 40,56
      do_reset();
      for (int k = 1; k <= 56; k++) begin
         btn_n = !((k >= 7 && k <= 16) || (k >= 31 && k <= 40));
         cyc();
         chk("t4_flag", k, flag, k == 40 || k == 56);
         chk("t4_run", k, running, k < 13 || k >= 37);
      end
      // 5: press completes on the terminal-count edge -> pulse still emitted, running drops together
      do_reset();
      for (int k = 1; k <= 34; k++) begin
         btn_n = !(k >= 10 && k <= 19);
         cyc();
         chk("t5_flag", k, flag, k == 16);
         chk("t5_run", k, running, k < 16);
      end
      // 6: reset with cnt=10, deb_cnt=2, button still held -> debounce restarts from scratch
      btn_n = 1'b1;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         btn_n = !(k >= 7);
         cyc();
      end
      do_reset();
      for (int j = 1; j <= 20; j++) begin
         cyc();
         chk("t6_flag", j, flag, 1'b0);
         chk("t6_run", j, running, j < 7);
      end
      // 7: reset on the would-be terminal edge emits nothing; first pulse 16 cycles later
      btn_n = 1'b1;
      do_reset();
      for (int k = 1; k <= 15; k++) cyc();
      do_reset();
      for (int j = 1; j <= 16; j++) begin
         cyc();
         chk("t7_flag", j, flag, j == 16);
      end
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
